rot_dma_arb: RTL and testbench
==============================

// Module: rot_dma_arb
// PURPOSE
// - Scheduler that shares the single AHB DMA master of the rotation engine between two requesters.
//   - Ch0 (read): source-pixel fetch.
//   - Ch1 (write): rotated-pixel store.
// - Round-robin arbitration; owns the HBUSREQ/HGRANT handshake.
// - Launches one burst at a time into the DMA engine and acknowledges the requester on completion.
// - Sits between core_set/core_pixel (requesters) and dma (bus engine) on HCLK.
// PARAMETERS
// - ADDR_W      32   width of burst start address
// - CNT_W       5    width of beat count (max 31 beats)
// - GNT_TIMEOUT 255  cycles in BUSREQ without grant before error flag sets
// PORTS
// - I_ARB_HCLK         in   1       HCLK; all logic rising-edge
// - I_ARB_RESET        in   1       synchronous, active-high reset
// - I_ARB_STOP         in   1       done/abort; blocks new grants
// - I_ARB_REQ          in   2       per-channel burst request, level, held until ACK
// - I_ARB_ADDR0/1      in   ADDR_W  per-channel burst start address, stable while REQ
// - I_ARB_COUNT0/1     in   CNT_W   per-channel beat count, stable while REQ
// - I_ARB_HGRANT       in   1       AHB bus grant
// - I_ARB_HREADY       in   1       AHB ready
// - I_ARB_DMA_DONE     in   1       1-cycle pulse from dma: burst finished
// - O_ARB_ACK          out  2       1-cycle pulse to the served channel
// - O_ARB_HBUSREQ      out  1       AHB bus request
// - O_ARB_DMA_START    out  1       1-cycle burst launch to dma
// - O_ARB_DMA_ADDR     out  ADDR_W  latched burst address
// - O_ARB_DMA_COUNT    out  CNT_W   latched beat count
// - O_ARB_DMA_WRITE    out  1       1 = ch1 (write), 0 = ch0 (read)
// - O_ARB_BUSY         out  1       state != IDLE
// - O_ARB_ERR          out  1       sticky grant-timeout flag
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; rr pointer favours ch0; timeout counter 0.
//   - Reset mid-burst abandons the burst, drops HBUSREQ next edge, and sends no ACK.
// - IDLE
//   - If STOP=0 and any REQ: pick a channel (both pending -> the channel not served last).
//   - Latch ADDR/COUNT/WRITE into O_ARB_DMA_*.
//   - COUNT==0 -> ACK (1-cycle pulse) with no bus activity; back to IDLE.
//   - Otherwise -> BUSREQ, with HBUSREQ=1 on the next cycle (REQ->HBUSREQ latency 1).
// - BUSREQ
//   - HBUSREQ held.
//   - HGRANT && HREADY -> ISSUE.
//   - Else increment timeout counter; at GNT_TIMEOUT: set ERR, drop HBUSREQ, go IDLE.
//   - After a timeout the request stays pending and is retried (pointer unchanged).
// - ISSUE: DMA_START=1 for exactly one cycle -> XFER. HBUSREQ held.
// - XFER
//   - HBUSREQ held until DMA_DONE.
//   - On DMA_DONE: ACK[sel]=1 for one cycle, pointer := other channel, HBUSREQ=0 -> IDLE.
//   - Mandatory 1-cycle bubble in IDLE between bursts.
// - STOP
//   - Affects IDLE only; a burst already in BUSREQ/ISSUE/XFER completes normally.
//   - A pending REQ during STOP is neither granted nor acked.
// - DMA_DONE outside XFER is ignored.
// - REQ deasserted before ACK is a requester protocol violation.
//   - Latched values are kept and the burst completes.
// - O_ARB_DMA_ADDR/COUNT/WRITE change only on the IDLE->BUSREQ transition.
// - ERR clears only on reset.
// STRUCTURE
// - Shared package (rot_pkg): state encodings ARB_IDLE/BUSREQ/ISSUE/XFER, CH_RD=0, CH_WR=1, CNT_W.
// - One sub-module, rot_rr_arb2: 2-input round-robin picker.
//   - Inputs: req[1:0], last.
//   - Outputs: sel, valid.
//   - Purely combinational.
// TESTING
// - Single read: REQ=01, ADDR0=0x1000, COUNT0=8; HGRANT after 3 cycles.
//   - Required: HBUSREQ at +1, DMA_START 1 cycle after grant, DMA_WRITE=0.
//   - Required: ACK=01 the cycle after DMA_DONE.
// - Contention: REQ=11 held.
//   - Required: serve order ch0, ch1, ch0 (alternating), one IDLE bubble between each.
//   - Required: DMA_ADDR switches 0x1000/0x8000.
// - Zero count: REQ=10, COUNT1=0.
//   - Required: ACK=10 after 1 cycle, HBUSREQ never high, DMA_START never pulses.
// - Timeout: REQ=01, HGRANT=0.
//   - Required: ERR=1 after 255 cycles, HBUSREQ drops.
//   - Then assert HGRANT: burst proceeds and ACK arrives; ERR stays 1.
// - STOP: assert STOP during XFER of ch0 with REQ=11.
//   - Required: ch0 ACKed; ch1 never granted while STOP=1; granted after STOP falls.
// - Reset mid-XFER.
//   - Required: all outputs 0 next cycle, no ACK; a later DMA_DONE is ignored.

Source files
------------

// File: rtl/rot_pkg.sv
// Shared definitions for the rotation engine DMA scheduling blocks.
package rot_pkg;

   // Beat-count width: a burst carries at most 31 beats.
   localparam int CNT_W = 5;

   // Channel identifiers. The index is also the bit position in the REQ and ACK vectors.
   localparam logic CH_RD = 1'b0;   // source-pixel fetch
   localparam logic CH_WR = 1'b1;   // rotated-pixel store

   // Arbiter FSM state encodings.
   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_BUSREQ = 2'd1,
      ARB_ISSUE  = 2'd2,
      ARB_XFER   = 2'd3
   } arb_state_e;

endpackage

// File: rtl/rot_rr_arb2.sv
// Two-input round-robin picker. This block is purely combinational.
// When both inputs request, it selects the channel that was not served last.
module rot_rr_arb2
   import rot_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       sel,
   output logic       valid
);

   // With a single requester, that requester wins. With two, the one not served last wins.
   always_comb begin
      valid = |req;
      sel   = req[1];
      if (req == 2'b11) sel = ~last;
   end

endmodule

// File: rtl/rot_dma_arb.sv
// Shares the rotation engine's AHB DMA master between the read (ch0) and write (ch1) requesters.
// The block owns the HBUSREQ/HGRANT handshake and launches one burst at a time.
module rot_dma_arb
   import rot_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int CNT_W       = rot_pkg::CNT_W,
   parameter int GNT_TIMEOUT = 255
) (
   input  logic              I_ARB_HCLK,
   input  logic              I_ARB_RESET,
   input  logic              I_ARB_STOP,
   input  logic [1:0]        I_ARB_REQ,
   input  logic [ADDR_W-1:0] I_ARB_ADDR0,
   input  logic [ADDR_W-1:0] I_ARB_ADDR1,
   input  logic [CNT_W-1:0]  I_ARB_COUNT0,
   input  logic [CNT_W-1:0]  I_ARB_COUNT1,
   input  logic              I_ARB_HGRANT,
   input  logic              I_ARB_HREADY,
   input  logic              I_ARB_DMA_DONE,
   output logic [1:0]        O_ARB_ACK,
   output logic              O_ARB_HBUSREQ,
   output logic              O_ARB_DMA_START,
   output logic [ADDR_W-1:0] O_ARB_DMA_ADDR,
   output logic [CNT_W-1:0]  O_ARB_DMA_COUNT,
   output logic              O_ARB_DMA_WRITE,
   output logic              O_ARB_BUSY,
   output logic              O_ARB_ERR
);

   localparam int TMO_W = $clog2(GNT_TIMEOUT + 1);

   arb_state_e        state_q, state_d;
   logic              last_q, last_d;     // channel served most recently
   logic              wr_q, wr_d;         // latched channel, which is also the write flag
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        ack_q, ack_d;
   logic              err_q, err_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;

   logic [1:0]        req_eff;
   logic              pick_sel;
   logic              pick_vld;
   logic [CNT_W-1:0]  pick_cnt;
   logic [ADDR_W-1:0] pick_addr;

   // A requester still holds REQ during the cycle in which it sees its ACK.
   // This mask prevents that stale level from being served a second time.
   assign req_eff = I_ARB_REQ & ~ack_q;

   rot_rr_arb2 u_rr (
      .req   (req_eff),
      .last  (last_q),
      .sel   (pick_sel),
      .valid (pick_vld)
   );

   assign pick_cnt  = (pick_sel == CH_WR) ? I_ARB_COUNT1 : I_ARB_COUNT0;
   assign pick_addr = (pick_sel == CH_WR) ? I_ARB_ADDR1  : I_ARB_ADDR0;

   // Next-state logic: arbitration, bus handshake, grant timeout, and completion ACK.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      ack_d   = 2'b00;
      err_d   = err_q;
      tmo_d   = tmo_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (!I_ARB_STOP && pick_vld) begin
               if (pick_cnt == '0) begin
                  // An empty burst is acknowledged directly, with no bus activity.
                  ack_d[pick_sel] = 1'b1;
                  last_d          = pick_sel;
               end else begin
                  state_d = ARB_BUSREQ;
                  wr_d    = pick_sel;
                  addr_d  = pick_addr;
                  cnt_d   = pick_cnt;
                  tmo_d   = '0;
               end
            end
         end
         ARB_BUSREQ: begin
            if (I_ARB_HGRANT && I_ARB_HREADY) begin
               state_d = ARB_ISSUE;
            end else if (tmo_q == TMO_W'(GNT_TIMEOUT - 1)) begin
               // Give up on this grant attempt. The request stays pending and is retried from IDLE.
               err_d   = 1'b1;
               tmo_d   = '0;
               state_d = ARB_IDLE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         ARB_ISSUE: begin
            state_d = ARB_XFER;
         end
         ARB_XFER: begin
            if (I_ARB_DMA_DONE) begin
               ack_d[wr_q] = 1'b1;
               last_d      = wr_q;
               state_d     = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // State and output registers. Reset abandons any burst in flight without sending an ACK.
   always_ff @(posedge I_ARB_HCLK) begin
      if (I_ARB_RESET) begin
         state_q <= ARB_IDLE;
         last_q  <= CH_WR;      // so that ch0 wins the first contention
         wr_q    <= 1'b0;
         addr_q  <= '0;
         cnt_q   <= '0;
         ack_q   <= 2'b00;
         err_q   <= 1'b0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         tmo_q   <= tmo_d;
      end
   end

   // HBUSREQ is held in every non-idle state, so it rises one cycle after REQ.
   assign O_ARB_HBUSREQ   = (state_q != ARB_IDLE);
   assign O_ARB_BUSY      = (state_q != ARB_IDLE);
   assign O_ARB_DMA_START = (state_q == ARB_ISSUE);
   assign O_ARB_ACK       = ack_q;
   assign O_ARB_DMA_ADDR  = addr_q;
   assign O_ARB_DMA_COUNT = cnt_q;
   assign O_ARB_DMA_WRITE = wr_q;
   assign O_ARB_ERR       = err_q;

endmodule

// File: tb/tb_rot_dma_arb.sv
// Scoreboard bench for rot_dma_arb.
// It models the requesters, the AHB grant, and the dma engine around the arbiter.
module tb_rot_dma_arb;
   import rot_pkg::*;

   localparam int ADDR_W = 32;

   logic              I_ARB_HCLK = 1'b0;
   logic              I_ARB_RESET;
   logic              I_ARB_STOP;
   logic [1:0]        I_ARB_REQ;
   logic [ADDR_W-1:0] I_ARB_ADDR0, I_ARB_ADDR1;
   logic [CNT_W-1:0]  I_ARB_COUNT0, I_ARB_COUNT1;
   logic              I_ARB_HGRANT;
   logic              I_ARB_HREADY;
   logic              I_ARB_DMA_DONE;
   logic [1:0]        O_ARB_ACK;
   logic              O_ARB_HBUSREQ, O_ARB_DMA_START, O_ARB_DMA_WRITE, O_ARB_BUSY, O_ARB_ERR;
   logic [ADDR_W-1:0] O_ARB_DMA_ADDR;
   logic [CNT_W-1:0]  O_ARB_DMA_COUNT;

   rot_dma_arb dut (
      .I_ARB_HCLK(I_ARB_HCLK), .I_ARB_RESET(I_ARB_RESET), .I_ARB_STOP(I_ARB_STOP),
      .I_ARB_REQ(I_ARB_REQ), .I_ARB_ADDR0(I_ARB_ADDR0), .I_ARB_ADDR1(I_ARB_ADDR1),
      .I_ARB_COUNT0(I_ARB_COUNT0), .I_ARB_COUNT1(I_ARB_COUNT1), .I_ARB_HGRANT(I_ARB_HGRANT),
      .I_ARB_HREADY(I_ARB_HREADY), .I_ARB_DMA_DONE(I_ARB_DMA_DONE), .O_ARB_ACK(O_ARB_ACK),
      .O_ARB_HBUSREQ(O_ARB_HBUSREQ), .O_ARB_DMA_START(O_ARB_DMA_START),
      .O_ARB_DMA_ADDR(O_ARB_DMA_ADDR), .O_ARB_DMA_COUNT(O_ARB_DMA_COUNT),
      .O_ARB_DMA_WRITE(O_ARB_DMA_WRITE), .O_ARB_BUSY(O_ARB_BUSY), .O_ARB_ERR(O_ARB_ERR)
   );

   always #5 I_ARB_HCLK = ~I_ARB_HCLK;

   int n_chk = 0, n_pass = 0;
   int cyc = 0;
   always @(posedge I_ARB_HCLK) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   // Scoreboard queues. exp_start holds {write, addr, count}; exp_ack holds {zero_count, ack_vector}.
   logic [ADDR_W+CNT_W:0] exp_start[$];
   logic [2:0]            exp_ack[$];
   logic [ADDR_W+CNT_W-1:0] jobs0[$], jobs1[$];

   // Behaviour knobs for the environment models.
   bit auto_gnt = 1;
   int gnt_dly = 3, gcnt = 0;
   int dma_lat = 4, dcnt = 0;
   logic model_done = 0, man_done = 0;
   assign I_ARB_DMA_DONE = model_done | man_done;

   int  rise_cyc = 0, gcyc = 0, done_cyc = 0, last_ack_cyc = 0;
   bit  gnt_seen = 0;
   int  st_cnt = 0, ack_cnt = 0, hb_cnt = 0;

   function automatic void expect_burst(input logic ch, input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] c);
      if (c != 0) exp_start.push_back({ch, a, c});
      exp_ack.push_back({(c == 0), (ch ? 2'b10 : 2'b01)});
   endfunction

   function automatic void job(input logic ch, input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] c);
      if (ch) jobs1.push_back({a, c});
      else    jobs0.push_back({a, c});
   endfunction

   // Environment monitor: checks first, then drives the requester, bus and dma models.
   always @(negedge I_ARB_HCLK) begin
      logic [ADDR_W+CNT_W:0] es;
      logic [2:0]            ea;
      logic [ADDR_W+CNT_W-1:0] j;
      if (!I_ARB_RESET) begin
         if (O_ARB_HBUSREQ) hb_cnt++;
         if (O_ARB_DMA_START) begin
            st_cnt++;
            if (exp_start.size() == 0) check("start_unexpected", exp_start.size(), 1);
            else begin
               es = exp_start.pop_front();
               check("start_wr_addr_cnt", {O_ARB_DMA_WRITE, O_ARB_DMA_ADDR, O_ARB_DMA_COUNT}, es);
               check("start_after_grant", cyc - gcyc, 1);
            end
         end
         if (O_ARB_ACK != 2'b00) begin
            ack_cnt++;
            last_ack_cyc = cyc;
            gnt_seen = 0;
            check("ack_idle_bubble", {O_ARB_BUSY, O_ARB_HBUSREQ}, 0);
            if (exp_ack.size() == 0) check("ack_unexpected", O_ARB_ACK, 0);
            else begin
               ea = exp_ack.pop_front();
               check("ack_channel", O_ARB_ACK, ea[1:0]);
               if (!ea[2]) check("ack_after_done", cyc - done_cyc, 1);
            end
         end
         // Requesters: hold REQ until ACK, then chain straight into the next queued job.
         for (int ch = 0; ch < 2; ch++) begin
            if (O_ARB_ACK[ch] || !I_ARB_REQ[ch]) begin
               if ((ch ? jobs1.size() : jobs0.size()) != 0) begin
                  j = ch ? jobs1.pop_front() : jobs0.pop_front();
                  if (ch) begin I_ARB_ADDR1 = j[ADDR_W+CNT_W-1:CNT_W]; I_ARB_COUNT1 = j[CNT_W-1:0]; end
                  else    begin I_ARB_ADDR0 = j[ADDR_W+CNT_W-1:CNT_W]; I_ARB_COUNT0 = j[CNT_W-1:0]; end
                  if (!I_ARB_REQ[ch]) rise_cyc = cyc;
                  I_ARB_REQ[ch] = 1'b1;
               end else I_ARB_REQ[ch] = 1'b0;
            end
         end
      end
      // AHB arbiter model: grants HBUSREQ after gnt_dly cycles.
      if (auto_gnt) begin
         if (O_ARB_HBUSREQ) begin
            if (gcnt >= gnt_dly) I_ARB_HGRANT = 1'b1;
            else gcnt++;
         end else begin
            I_ARB_HGRANT = 1'b0;
            gcnt = 0;
         end
      end
      if (I_ARB_HGRANT && I_ARB_HREADY && O_ARB_HBUSREQ && !gnt_seen && !I_ARB_RESET) begin
         gcyc = cyc;
         gnt_seen = 1;
      end
      // dma model: DONE pulses dma_lat cycles after START.
      model_done = 1'b0;
      if (dcnt > 0) begin
         dcnt--;
         if (dcnt == 0) begin model_done = 1'b1; done_cyc = cyc; end
      end
      if (O_ARB_DMA_START && !I_ARB_RESET) dcnt = dma_lat;
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge I_ARB_HCLK);
   endtask

   task automatic do_reset();
      @(negedge I_ARB_HCLK);
      I_ARB_RESET = 1'b1;
      I_ARB_REQ = 2'b00; I_ARB_STOP = 1'b0;
      jobs0.delete(); jobs1.delete(); exp_start.delete(); exp_ack.delete();
      dcnt = 0; gnt_seen = 0;
      wait_cycles(2);
      I_ARB_RESET = 1'b0;
   endtask

   task automatic drain(input string tag, input int max);
      for (int i = 0; i < max; i++) begin
         if (exp_ack.size() == 0 && exp_start.size() == 0 && jobs0.size() == 0 && jobs1.size() == 0 &&
             I_ARB_REQ == 2'b00 && !O_ARB_BUSY) break;
         @(negedge I_ARB_HCLK);
      end
      check(tag, exp_ack.size() + exp_start.size() + jobs0.size() + jobs1.size(), 0);
   endtask

   int c0, c1, s0, a0, h0;

   initial begin
      I_ARB_RESET = 1'b1; I_ARB_STOP = 1'b0; I_ARB_REQ = 2'b00;
      I_ARB_ADDR0 = '0; I_ARB_ADDR1 = '0; I_ARB_COUNT0 = '0; I_ARB_COUNT1 = '0;
      I_ARB_HGRANT = 1'b0; I_ARB_HREADY = 1'b1;
      wait_cycles(3);
      check("rst_outputs", {O_ARB_ACK, O_ARB_HBUSREQ, O_ARB_DMA_START, O_ARB_DMA_WRITE, O_ARB_BUSY, O_ARB_ERR}, 0);
      check("rst_addr_cnt", {O_ARB_DMA_ADDR, O_ARB_DMA_COUNT}, 0);
      I_ARB_RESET = 1'b0;
      wait_cycles(2);

      // Single read burst.
      gnt_dly = 3; dma_lat = 4;
      expect_burst(CH_RD, 32'h1000, 5'd8);
      job(CH_RD, 32'h1000, 5'd8);
      for (int i = 0; i < 50 && !O_ARB_HBUSREQ; i++) @(negedge I_ARB_HCLK);
      check("rd_busreq_latency", cyc - rise_cyc, 1);
      drain("rd_drain", 100);

      // Contention: ch0 is favoured after reset, then service alternates.
      do_reset();
      gnt_dly = 1; dma_lat = 3;
      for (int k = 0; k < 3; k++) begin
         expect_burst(CH_RD, 32'h1000 + 32'h100 * k, 5'd4 + 5'(k));
         expect_burst(CH_WR, 32'h8000 + 32'h100 * k, 5'd16 + 5'(k));
         job(CH_RD, 32'h1000 + 32'h100 * k, 5'd4 + 5'(k));
         job(CH_WR, 32'h8000 + 32'h100 * k, 5'd16 + 5'(k));
      end
      drain("rr_drain", 300);

      // Zero-count write: ACK with no bus activity.
      s0 = st_cnt; h0 = hb_cnt;
      expect_burst(CH_WR, 32'h4444, 5'd0);
      job(CH_WR, 32'h4444, 5'd0);
      drain("zc_drain", 20);
      check("zc_ack_latency", last_ack_cyc - rise_cyc, 1);
      check("zc_no_busreq", hb_cnt - h0, 0);
      check("zc_no_start", st_cnt - s0, 0);
      check("zc_addr_unchanged", O_ARB_DMA_ADDR, 32'h8200);

      // STOP asserted during the ch0 transfer blocks ch1 until STOP falls.
      dma_lat = 10;
      expect_burst(CH_RD, 32'h2000, 5'd4);
      expect_burst(CH_WR, 32'h9000, 5'd7);
      s0 = st_cnt; a0 = ack_cnt;
      job(CH_RD, 32'h2000, 5'd4);
      job(CH_WR, 32'h9000, 5'd7);
      for (int i = 0; i < 50 && st_cnt == s0; i++) @(negedge I_ARB_HCLK);
      I_ARB_STOP = 1'b1;
      for (int i = 0; i < 50 && ack_cnt == a0; i++) @(negedge I_ARB_HCLK);
      check("stop_ch0_acked", ack_cnt - a0, 1);
      wait_cycles(20);
      check("stop_no_grant", {st_cnt - s0, 30'd0, O_ARB_BUSY, O_ARB_HBUSREQ}, {32'd1, 32'd0});
      check("stop_ch1_pending", I_ARB_REQ, 2'b10);
      I_ARB_STOP = 1'b0;
      drain("stop_drain", 100);

      // Grant timeout: ERR after 255 cycles, then retry succeeds.
      @(negedge I_ARB_HCLK);
      auto_gnt = 0; I_ARB_HGRANT = 1'b0;
      dma_lat = 3;
      expect_burst(CH_RD, 32'h3000, 5'd2);
      job(CH_RD, 32'h3000, 5'd2);
      c0 = 0; c1 = 0;
      for (int i = 0; i < 20 && !O_ARB_HBUSREQ; i++) @(negedge I_ARB_HCLK);
      c0 = cyc;
      for (int i = 0; i < 400 && !O_ARB_ERR; i++) @(negedge I_ARB_HCLK);
      c1 = cyc;
      check("tmo_cycles", c1 - c0, 255);
      check("tmo_err_busreq", {O_ARB_ERR, O_ARB_HBUSREQ}, 2'b10);
      gnt_dly = 0; auto_gnt = 1;
      drain("tmo_retry_drain", 100);
      check("tmo_err_sticky", O_ARB_ERR, 1'b1);

      // Reset mid-transfer: outputs clear, no ACK, and a late DONE is ignored.
      dma_lat = 20;
      expect_burst(CH_WR, 32'hA000, 5'd6);
      s0 = st_cnt;
      job(CH_WR, 32'hA000, 5'd6);
      for (int i = 0; i < 50 && st_cnt == s0; i++) @(negedge I_ARB_HCLK);
      wait_cycles(2);
      check("xfer_busy", O_ARB_BUSY, 1'b1);
      I_ARB_RESET = 1'b1; I_ARB_REQ = 2'b00;
      jobs0.delete(); jobs1.delete(); exp_start.delete(); exp_ack.delete();
      dcnt = 0; gnt_seen = 0;
      @(negedge I_ARB_HCLK);
      check("mid_rst_outputs", {O_ARB_ACK, O_ARB_HBUSREQ, O_ARB_DMA_START, O_ARB_DMA_WRITE, O_ARB_BUSY, O_ARB_ERR}, 0);
      check("mid_rst_addr_cnt", {O_ARB_DMA_ADDR, O_ARB_DMA_COUNT}, 0);
      I_ARB_RESET = 1'b0;
      a0 = ack_cnt;
      wait_cycles(2);
      man_done = 1'b1;
      @(negedge I_ARB_HCLK);
      man_done = 1'b0;
      wait_cycles(5);
      check("late_done_no_ack", ack_cnt - a0, 0);
      check("late_done_idle", {O_ARB_BUSY, O_ARB_HBUSREQ, O_ARB_ACK}, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
